// File: rtl/vga_pixel_fetch.sv
// vga_pixel_fetch
//   Display-side pixel source. Prefetches one 1-bpp source line per display
//   line from frame memory into a ping-pong line buffer, upscales 2x in both
//   axes and drives 4-bit-per-channel RGB. hsync/vsync are delayed by the same
//   single pixel stage as the colour so both stay aligned at the DAC.
//
// Ports
//   CLK_40      : system clock
//   reset       : synchronous, active-high
//   pixel_en    : one-cycle pixel enable (at most one per 4 clocks)
//   x_pos/y_pos : screen counters from the sync generators
//   h_BLANK/v_BLANK, hsync_in/vsync_in : blanking flags and sync levels
//   frame_base  : word address of the next frame's first word
//   mem_rd/mem_addr            : one-cycle read strobe and its address
//   mem_rvalid/mem_rdata       : read response, latency >= 1 cycle
//   vga_rgb, vga_hsync, vga_vsync : registered pixel outputs
//   underrun    : sticky, a line was shown before its fetch completed
module vga_pixel_fetch #(
  parameter int          H_AREA   = 640,
  parameter int          V_AREA   = 480,
  parameter int          H_TOTAL  = 800,
  parameter int          V_TOTAL  = 525,
  parameter int          SRC_W    = 320,
  parameter int          WORD_W   = 16,
  parameter int          ADDR_W   = 17,
  parameter logic [11:0] FG_COLOR = 12'hFFF
) (
  input  logic              CLK_40,
  input  logic              reset,
  input  logic              pixel_en,
  input  logic [9:0]        x_pos,
  input  logic [9:0]        y_pos,
  input  logic              h_BLANK,
  input  logic              v_BLANK,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic [ADDR_W-1:0] frame_base,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rvalid,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic [11:0]       vga_rgb,
  output logic              vga_hsync,
  output logic              vga_vsync,
  output logic              underrun
);

  localparam int WORDS = SRC_W / WORD_W;
  localparam int KW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int BW    = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  if ((SRC_W % WORD_W) != 0 || SRC_W * 2 != H_AREA ||
      H_TOTAL <= H_AREA || V_TOTAL <= V_AREA) begin : g_bad_cfg
    $error("vga_pixel_fetch: inconsistent geometry parameters");
  end

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t            state;
  logic [KW-1:0]     k;
  logic              fill_ok;
  logic              line_ok;
  logic              disp_bank;
  logic [ADDR_W-1:0] base_r;
  logic [ADDR_W-1:0] line_base;

  // Ping-pong line buffer; bank disp_bank is shown, the other one is filled.
  logic [WORD_W-1:0] line_buf [2][WORDS];

  logic [9:0] ny;
  logic [8:0] sy;
  logic       fetch_trig;
  logic       swap;
  logic       swap_abort;

  assign ny         = (y_pos == 10'(V_TOTAL - 1)) ? 10'd0 : y_pos + 10'd1;
  assign sy         = ny[9:1];
  assign fetch_trig = pixel_en && (x_pos == 10'(H_AREA)) && (ny < 10'(V_AREA));
  assign swap       = pixel_en && (x_pos == 10'd0) && (y_pos < 10'(V_AREA));
  assign swap_abort = swap && !fill_ok;

  // The first line of a frame uses the frame_base presented with its trigger;
  // every later line of the frame reuses the latched copy.
  logic [ADDR_W-1:0] base_sel;
  assign base_sel = (ny == 10'd0) ? frame_base : base_r;

  // Fetch control: one outstanding read at a time, strobe registered.
  always_ff @(posedge CLK_40) begin
    if (reset) begin
      state     <= S_IDLE;
      k         <= '0;
      fill_ok   <= 1'b0;
      line_ok   <= 1'b0;
      disp_bank <= 1'b0;
      base_r    <= '0;
      line_base <= '0;
      underrun  <= 1'b0;
      mem_rd    <= 1'b0;
      mem_addr  <= '0;
    end else begin
      mem_rd <= 1'b0;

      case (state)
        S_IDLE: begin
          state <= S_IDLE;
        end
        S_REQ: begin
          mem_rd   <= 1'b1;
          mem_addr <= line_base + ADDR_W'(k);
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (mem_rvalid) begin
            if (k == KW'(WORDS - 1)) begin
              fill_ok <= 1'b1;
              state   <= S_IDLE;
            end else begin
              k     <= k + KW'(1);
              state <= S_REQ;
            end
          end
        end
        default: state <= S_IDLE;
      endcase

      // Line start: show the freshly filled bank. An incomplete fill means
      // this line is shown black and the stale fetch is dropped.
      if (swap) begin
        disp_bank <= ~disp_bank;
        line_ok   <= fill_ok;
        if (!fill_ok) begin
          underrun <= 1'b1;
          state    <= S_IDLE;
          mem_rd   <= 1'b0;
        end
      end

      // A new trigger while still busy is an overrun of the previous line;
      // flag it and restart for the new line.
      if (fetch_trig) begin
        if (state != S_IDLE) begin
          underrun <= 1'b1;
          mem_rd   <= 1'b0;
        end
        if (ny == 10'd0) begin
          base_r <= frame_base;
        end
        line_base <= base_sel + ADDR_W'(sy) * ADDR_W'(WORDS);
        k         <= '0;
        fill_ok   <= 1'b0;
        state     <= S_REQ;
      end
    end
  end

  // Line buffer fill: data path only, no reset.
  always_ff @(posedge CLK_40) begin
    if (!reset && state == S_WAIT && mem_rvalid) begin
      line_buf[~disp_bank][k] <= mem_rdata;
    end
  end

  // ---- pixel stage p0: select the source bit for the sampled x_pos ----
  // The swap takes effect on the same pixel_en as x_pos==0, so the bank and
  // line status used here are the post-swap values.
  logic              vld_p0;
  logic              disp_nxt_p0;
  logic              line_ok_p0;
  logic [9:0]        src_x_p0;
  logic [9:0]        word_idx_p0;
  logic [9:0]        bit_idx_p0;
  logic              in_range_p0;
  logic [WORD_W-1:0] word_p0;
  logic              pix_bit_p0;
  logic              blank_p0;

  assign vld_p0 = pixel_en;

  always_comb begin
    disp_nxt_p0 = swap ? ~disp_bank : disp_bank;
    line_ok_p0  = swap ? fill_ok : line_ok;
    src_x_p0    = {1'b0, x_pos[9:1]};
    word_idx_p0 = src_x_p0 / 10'(WORD_W);
    bit_idx_p0  = src_x_p0 % 10'(WORD_W);
    in_range_p0 = word_idx_p0 < 10'(WORDS);
    word_p0     = line_buf[disp_nxt_p0][in_range_p0 ? KW'(word_idx_p0) : KW'(0)];
    // MSB of each word is the leftmost pixel.
    pix_bit_p0  = word_p0[BW'(10'(WORD_W - 1) - bit_idx_p0)];
    blank_p0    = h_BLANK | v_BLANK | ~line_ok_p0 | (x_pos >= 10'(H_AREA));
  end

  // ---- pixel stage p1: registered colour and sync, held between enables ----
  always_ff @(posedge CLK_40) begin
    if (reset) begin
      vga_rgb   <= 12'h000;
      vga_hsync <= 1'b0;
      vga_vsync <= 1'b0;
    end else if (vld_p0) begin
      vga_rgb   <= (blank_p0 || !pix_bit_p0) ? 12'h000 : FG_COLOR;
      vga_hsync <= hsync_in;
      vga_vsync <= vsync_in;
    end
  end

endmodule
